siren_sequencer: RTL and testbench

- Pattern controller for the two-tone police siren tone generator; decides which tone sounds, when, and at what divider value.
- Drives a programmable tone divider via div_val, tone_en and tone_sel.
- Supports three patterns: hi-lo alternation, wail (slow sweep) and yelp (fast sweep).
- Sits between the user/control logic (start, stop, mode) and the siren clock-divider datapath.

---
 rtl/siren_sequencer.sv | 167 ++++++++++++++++
 tb/tb_siren_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/siren_sequencer.sv
// rtl/siren_sequencer.sv - hi-lo / wail / yelp pattern controller for the siren tone divider (optional burst mode: SIREN_BURST_EN)
module siren_sequencer #(
    parameter int DIV_W      = 16,
    parameter int DIV_HI     = 100,
    parameter int DIV_LO     = 150,
    parameter int HILO_HOLD  = 1000,
    parameter int WAIL_DWELL = 20,
    parameter int YELP_DWELL = 2,
    parameter int BURST_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    output logic             tone_en,
    output logic             tone_sel,
    output logic [DIV_W-1:0] div_val,
    output logic             busy,
    output logic             period_done,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, HI, LO, SWEEP_UP, SWEEP_DN} state_t;

    localparam int MAX_A = (HILO_HOLD > WAIL_DWELL) ? HILO_HOLD : WAIL_DWELL;
    localparam int MAX_C = (MAX_A > YELP_DWELL) ? MAX_A : YELP_DWELL;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [DIV_W-1:0] D_HI    = DIV_W'(DIV_HI);
    localparam logic [DIV_W-1:0] D_LO    = DIV_W'(DIV_LO);
    localparam logic [DIV_W-1:0] D_HI_P1 = DIV_W'(DIV_HI + 1);
    localparam logic [DIV_W-1:0] D_LO_M1 = DIV_W'(DIV_LO - 1);
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HILO_HOLD - 1);
    localparam logic [CNT_W-1:0] WAIL_M1 = CNT_W'(WAIL_DWELL - 1);
    localparam logic [CNT_W-1:0] YELP_M1 = CNT_W'(YELP_DWELL - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DIV_W-1:0]   div_n;
    logic [1:0]         mode_q, mode_n;
    logic               sel_n, pd_n, active_q, active_n;
    logic               period_end, burst_end;
    logic [CNT_W-1:0]   dwell_m1;

    // mode_q only ever holds 01 for wail; any other latched sweep mode is yelp
    assign dwell_m1 = (mode_q == 2'b01) ? WAIL_M1 : YELP_M1;
    assign tone_en  = active_q;
    assign busy     = active_q;

`ifdef SIREN_BURST_EN
    localparam int PC_W = $clog2(BURST_LEN + 1);
    logic [PC_W-1:0] pcnt, pcnt_n;
    logic            done_n;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        div_n      = div_val;
        sel_n      = tone_sel;
        mode_n     = mode_q;
        period_end = 1'b0;
        burst_end  = 1'b0;
        case (state)
            IDLE: if (start) begin
                mode_n = mode;
                cnt_n  = '0;
                sel_n  = 1'b1;
                if (mode == 2'b01 || mode == 2'b10) begin
                    state_n = SWEEP_UP;
                    div_n   = D_LO;
                end else begin
                    state_n = HI;
                    div_n   = D_HI;
                end
            end
            HI: if (cnt == HOLD_M1) begin
                state_n = LO;
                cnt_n   = '0;
                sel_n   = 1'b0;
                div_n   = D_LO;
            end else cnt_n = cnt + CNT_W'(1);
            LO: if (cnt == HOLD_M1) begin
                state_n    = HI;
                cnt_n      = '0;
                sel_n      = 1'b1;
                div_n      = D_HI;
                period_end = 1'b1;
            end else cnt_n = cnt + CNT_W'(1);
            SWEEP_UP: if (cnt == dwell_m1) begin
                cnt_n = '0;
                if (div_val == D_HI_P1) begin
                    state_n = SWEEP_DN;
                    sel_n   = 1'b0;
                    div_n   = D_HI;
                end else div_n = div_val - DIV_W'(1);
            end else cnt_n = cnt + CNT_W'(1);
            SWEEP_DN: if (cnt == dwell_m1) begin
                cnt_n = '0;
                if (div_val == D_LO_M1) begin
                    state_n    = SWEEP_UP;
                    sel_n      = 1'b1;
                    div_n      = D_LO;
                    period_end = 1'b1;
                end else div_n = div_val + DIV_W'(1);
            end else cnt_n = cnt + CNT_W'(1);
            default: state_n = IDLE;
        endcase

`ifdef SIREN_BURST_EN
        pcnt_n = pcnt;
        if (period_end) begin
            if (pcnt == PC_W'(BURST_LEN - 1)) burst_end = 1'b1;
            else pcnt_n = pcnt + PC_W'(1);
        end
`endif

        // stop has priority over start, every transition and burst completion
        pd_n = period_end & ~stop;
        if (stop || burst_end) begin
            state_n = IDLE;
            cnt_n   = '0;
            sel_n   = 1'b0;
            div_n   = D_LO;
        end
        active_n = (state_n != IDLE);

`ifdef SIREN_BURST_EN
        done_n = burst_end & ~stop;
        if (state_n == IDLE) pcnt_n = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_val     <= D_LO;
            tone_sel    <= 1'b0;
            mode_q      <= 2'b00;
            active_q    <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            div_val     <= div_n;
            tone_sel    <= sel_n;
            mode_q      <= mode_n;
            active_q    <= active_n;
            period_done <= pd_n;
        end
    end

`ifdef SIREN_BURST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            done <= 1'b0;
        end else begin
            pcnt <= pcnt_n;
            done <= done_n;
        end
    end
`else
    assign done = 1'b0;
`endif
endmodule

// File: tb/tb_siren_sequencer.sv
// tb/tb_siren_sequencer.sv - scoreboard bench for siren_sequencer with an arithmetic pattern model
module tb_siren_sequencer;
    localparam int DIV_W = 16, DIV_HI = 10, DIV_LO = 14, HILO_HOLD = 4;
    localparam int WAIL_DWELL = 3, YELP_DWELL = 1, BURST_LEN = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic tone_en, tone_sel, busy, period_done, done;
    logic [DIV_W-1:0] div_val;

    siren_sequencer #(
        .DIV_W(DIV_W), .DIV_HI(DIV_HI), .DIV_LO(DIV_LO), .HILO_HOLD(HILO_HOLD),
        .WAIL_DWELL(WAIL_DWELL), .YELP_DWELL(YELP_DWELL), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .tone_en(tone_en), .tone_sel(tone_sel), .div_val(div_val), .busy(busy),
        .period_done(period_done), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic sel;
        int   div;
        logic pd;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // reference model: a running pattern is just (mode, cycles since start)
    bit m_active = 0;
    int m_t      = 0;
    int m_mode   = 0;

    task automatic step(input logic s, input logic p, input logic [1:0] m);
        exp_t e;
        int per, phase, stp, rng, dw;
        start = s; stop = p; mode = m;
        @(posedge clk);
        cyc++;
        e = '{en: 1'b0, sel: 1'b0, div: DIV_LO, pd: 1'b0, done: 1'b0};
        if (!rst || p) m_active = 0;
        else if (!m_active) begin
            if (s) begin m_active = 1; m_t = 0; m_mode = int'(m); end
        end else m_t++;
        if (m_active) begin
            e.en = 1'b1;
            if (m_mode == 1 || m_mode == 2) begin
                dw    = (m_mode == 1) ? WAIL_DWELL : YELP_DWELL;
                rng   = DIV_LO - DIV_HI;
                per   = 2 * rng * dw;
                phase = m_t % per;
                stp   = phase / dw;
                e.sel = (stp < rng);
                e.div = (stp < rng) ? DIV_LO - stp : DIV_HI + (stp - rng);
            end else begin
                per   = 2 * HILO_HOLD;
                phase = m_t % per;
                e.sel = (phase < HILO_HOLD);
                e.div = e.sel ? DIV_HI : DIV_LO;
            end
            e.pd = (m_t > 0 && phase == 0);
`ifdef SIREN_BURST_EN
            if (e.pd && (m_t / per) == BURST_LEN) begin
                e = '{en: 1'b0, sel: 1'b0, div: DIV_LO, pd: 1'b1, done: 1'b1};
                m_active = 0;
            end
`endif
        end
        exp_q.push_back(e);
        #1;
        start = 1'b0; stop = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (tone_en !== e.en || busy !== e.en || tone_sel !== e.sel ||
                div_val !== DIV_W'(e.div) || period_done !== e.pd || done !== e.done) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: got en=%b busy=%b sel=%b div=%0d pd=%b done=%b, expected en=%b busy=%b sel=%b div=%0d pd=%b done=%b",
                         cyc, tone_en, busy, tone_sel, div_val, period_done, done,
                         e.en, e.en, e.sel, e.div, e.pd, e.done);
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (tone_en !== 1'b0 || busy !== 1'b0 || tone_sel !== 1'b0 ||
            div_val !== DIV_W'(DIV_LO) || period_done !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got en=%b busy=%b sel=%b div=%0d pd=%b done=%b, expected en=0 busy=0 sel=0 div=%0d pd=0 done=0",
                     name, tone_en, busy, tone_sel, div_val, period_done, done, DIV_LO);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b1;

        repeat (5) step(0, 0, 2'b00);
        step(1, 0, 2'b00);
        for (int i = 0; i < 20; i++) step((i % 7) == 3, 0, (i == 3) ? 2'b01 : 2'b00);
        step(0, 1, 2'b00);

        step(1, 0, 2'b01);
        for (int i = 0; i < 30; i++) step(0, 0, 2'b01);
        step(0, 1, 2'b01);

        step(1, 0, 2'b10);
        for (int i = 0; i < 5; i++) step(0, 0, 2'b10);
        for (int i = 0; i < 12; i++) step(0, 0, 2'b00);
        step(0, 1, 2'b00);

        step(1, 0, 2'b01);
        for (int i = 0; i < 7; i++) step(0, 0, 2'b01);
        step(0, 1, 2'b01);
        step(1, 1, 2'b00);
        repeat (3) step(0, 0, 2'b00);
        step(1, 0, 2'b11);
        for (int i = 0; i < 10; i++) step(0, 0, 2'b11);
        step(0, 1, 2'b00);

        step(1, 0, 2'b00);
        for (int i = 0; i < 5; i++) step(0, 0, 2'b00);
        #5;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        step(1, 0, 2'b00);
        step(0, 0, 2'b00);
        rst = 1'b1;
        step(1, 0, 2'b00);
        for (int i = 0; i < 10; i++) step(0, 0, 2'b00);
        step(0, 1, 2'b00);

`ifdef SIREN_BURST_EN
        step(1, 0, 2'b00);
        for (int i = 0; i < 20; i++) step(0, 0, 2'b00);
`endif

        for (int i = 0; i < 2000; i++) begin
            logic s, p;
            logic [1:0] m;
            s = ($urandom_range(0, 15) == 0);
            p = ($urandom_range(0, 149) == 0);
            m = 2'($urandom_range(0, 3));
            step(s, p, m);
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
